// File: rtl/transmitter_wrapper.sv
`default_nettype none
// ============================================================================
// Module : transmitter_wrapper
// Brief  : Word FIFO feeding a UART serialiser, 4 bytes per word, LSB first.
// Rev    : 1.0
// ============================================================================
module transmitter_wrapper #(
    parameter int TRANSMITTER_PERIOD = 868,
    parameter int OUT_BUFFER_WIDTH   = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] in,
    input  logic        valid,
    output logic        ready,
    output logic        out
);
    localparam int BAUD_W = $clog2(TRANSMITTER_PERIOD);
    localparam int DEPTH  = 2 ** OUT_BUFFER_WIDTH;
    localparam logic [BAUD_W-1:0]           BAUD_LAST = BAUD_W'(TRANSMITTER_PERIOD - 1);
    localparam logic [OUT_BUFFER_WIDTH-1:0] PTR_ONE   = OUT_BUFFER_WIDTH'(1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    logic [31:0]                 mem_q [DEPTH];
    logic [OUT_BUFFER_WIDTH-1:0] in_ptr_q, out_ptr_q, out_ptr_d;
    logic [OUT_BUFFER_WIDTH-1:0] in_ptr_inc;
    state_t                      state_q, state_d;
    logic [1:0]                  byte_idx_q, byte_idx_d;
    logic [2:0]                  bit_idx_q, bit_idx_d;
    logic [BAUD_W-1:0]           baud_q, baud_d;
    logic [7:0]                  shift_q, shift_d;
    logic                        out_q, out_d;
    logic [31:0]                 rd_word;
    logic [7:0]                  rd_byte;
    logic                        empty, full, push, baud_tick;

    assign in_ptr_inc = in_ptr_q + PTR_ONE;
    assign empty      = (in_ptr_q == out_ptr_q);
    assign full       = (in_ptr_inc == out_ptr_q);
    assign ready      = !full;
    assign push       = valid && ready;
    assign out        = out_q;
    assign baud_tick  = (baud_q == BAUD_LAST);
    assign rd_word    = mem_q[out_ptr_q];

    always_comb begin
        rd_byte = rd_word[7:0];
        case (byte_idx_q)
            2'd0:    rd_byte = rd_word[7:0];
            2'd1:    rd_byte = rd_word[15:8];
            2'd2:    rd_byte = rd_word[23:16];
            default: rd_byte = rd_word[31:24];
        endcase
    end

    // Storage has no reset: contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[in_ptr_q] <= in;
        end
    end

    // out_d is derived from the current state, so the line lags the FSM by one clock.
    always_comb begin
        state_d    = state_q;
        out_ptr_d  = out_ptr_q;
        byte_idx_d = byte_idx_q;
        bit_idx_d  = bit_idx_q;
        baud_d     = baud_q;
        shift_d    = shift_q;
        out_d      = 1'b1;
        case (state_q)
            S_IDLE: begin
                out_d = 1'b1;
                if (!empty) begin
                    shift_d = rd_byte;
                    baud_d  = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                out_d = 1'b0;
                if (baud_tick) begin
                    baud_d    = '0;
                    bit_idx_d = '0;
                    state_d   = S_DATA;
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            S_DATA: begin
                out_d = shift_q[0];
                if (baud_tick) begin
                    baud_d  = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    if (bit_idx_q == 3'd7) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
            default: begin
                out_d = 1'b1;
                if (baud_tick) begin
                    baud_d  = '0;
                    state_d = S_IDLE;
                    if (byte_idx_q == 2'd3) begin
                        out_ptr_d  = out_ptr_q + PTR_ONE;
                        byte_idx_d = 2'd0;
                    end else begin
                        byte_idx_d = byte_idx_q + 1'b1;
                    end
                end else begin
                    baud_d = baud_q + 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ptr_q   <= '0;
            out_ptr_q  <= '0;
            state_q    <= S_IDLE;
            byte_idx_q <= '0;
            bit_idx_q  <= '0;
            baud_q     <= '0;
            shift_q    <= '0;
            out_q      <= 1'b1;
        end else begin
            if (push) begin
                in_ptr_q <= in_ptr_inc;
            end
            out_ptr_q  <= out_ptr_d;
            state_q    <= state_d;
            byte_idx_q <= byte_idx_d;
            bit_idx_q  <= bit_idx_d;
            baud_q     <= baud_d;
            shift_q    <= shift_d;
            out_q      <= out_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_transmitter_wrapper.sv
`default_nettype none
// ============================================================================
// Module : tb_transmitter_wrapper
// Brief  : Randomised bench with a byte-queue reference and mid-bit UART monitor.
// Rev    : 1.0
// ============================================================================
module tb_transmitter_wrapper;
    localparam int P = 4;
    localparam int W = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] din = '0;
    logic        dvalid = 1'b0;
    logic        dready;
    logic        dout;

    int          cyc = 0;
    int          n_chk = 0;
    int          n_fail = 0;
    logic [7:0]  exp_q[$];

    transmitter_wrapper #(
        .TRANSMITTER_PERIOD(P),
        .OUT_BUFFER_WIDTH  (W)
    ) dut (
        .clk  (clk),
        .rst  (rst),
        .in   (din),
        .valid(dvalid),
        .ready(dready),
        .out  (dout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Holds valid until the word is taken; returns the index of the accepting edge.
    task automatic push(input logic [31:0] d, output int acc);
        logic taken;
        taken  = 1'b0;
        acc    = -1;
        din    = d;
        dvalid = 1'b1;
        for (int n = 0; n < 2000 && !taken; n++) begin
            if (dready) begin
                taken = 1'b1;
                acc   = cyc + 1;
                for (int b = 0; b < 4; b++) exp_q.push_back(8'(d >> (8 * b)));
            end
            @(negedge clk);
        end
        dvalid = 1'b0;
        if (!taken) chk("push_accepted", {31'b0, taken}, 32'd1);
    endtask

    task automatic wait_cyc(input int target);
        while (cyc < target) @(negedge clk);
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 20000) begin
            @(negedge clk);
            n++;
        end
        if (exp_q.size() != 0) chk("drain", 32'(exp_q.size()), 32'd0);
        repeat (10) @(negedge clk);
    endtask

    // UART monitor: samples every clock of a frame, decodes at mid-bit.
    logic [39:0] s;
    logic        abort;
    int          st;
    int          last_start = -1;
    int          byte_in_word = 0;
    int          width_ok;
    logic [7:0]  rx, ex;
    initial begin
        forever begin
            @(negedge clk);
            if (!rst && dout === 1'b0) begin
                st = cyc;
                if (last_start >= 0 && byte_in_word != 0)
                    chk("frame_gap", 32'(st - last_start), 32'd41);
                s     = '0;
                s[0]  = dout;
                abort = 1'b0;
                for (int i = 1; i < 40 && !abort; i++) begin
                    @(negedge clk);
                    if (rst) abort = 1'b1;
                    else     s[i] = dout;
                end
                if (abort) begin
                    last_start   = -1;
                    byte_in_word = 0;
                end else begin
                    width_ok = 0;
                    for (int k = 0; k < 10; k++)
                        if (s[4*k] == s[4*k+1] && s[4*k] == s[4*k+2] && s[4*k] == s[4*k+3])
                            width_ok++;
                    chk("bit_width", 32'(width_ok), 32'd10);
                    chk("start_bit", {31'b0, s[2]}, 32'd0);
                    chk("stop_bit", {31'b0, s[38]}, 32'd1);
                    for (int j = 0; j < 8; j++) rx[j] = s[4*(j+1)+2];
                    if (exp_q.size() == 0) begin
                        chk("byte_unexpected", {24'b0, rx}, 32'hFFFF_FFFF);
                    end else begin
                        ex = exp_q.pop_front();
                        chk("rx_byte", {24'b0, rx}, {24'b0, ex});
                    end
                    last_start   = st;
                    byte_in_word = (byte_in_word + 1) % 4;
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    int a, a0, a1;
    initial begin
        // Reset state, observed while rst is held
        @(negedge clk);
        chk("rst_out", {31'b0, dout}, 32'd1);
        chk("rst_ready", {31'b0, dready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);

        // Single word and first-byte latency
        push(32'h4433_2211, a);
        wait_cyc(a + 1);
        chk("lat_out_e1", {31'b0, dout}, 32'd1);
        wait_cyc(a + 2);
        chk("lat_out_e2", {31'b0, dout}, 32'd0);
        wait_cyc(a + 2 + 164);
        chk("word_end_idle", {31'b0, dout}, 32'd1);
        drain();

        // Fill to capacity, then hold an extra word against a full FIFO
        push($urandom, a0);
        for (int i = 1; i < 15; i++) push($urandom, a);
        chk("full_ready", {31'b0, dready}, 32'd0);
        din    = 32'hDEAD_BEEF;
        dvalid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("hold_ready", {31'b0, dready}, 32'd0);
        end
        push(32'hDEAD_BEEF, a1);
        chk("ready_return", 32'(a1), 32'(a0 + 165));
        drain();

        // Randomly spaced pushes while the serialiser drains; pointers wrap
        for (int i = 0; i < 20; i++) begin
            repeat ($urandom_range(0, 30)) @(negedge clk);
            push($urandom, a);
        end
        drain();

        // Reset in the middle of byte 2's data bits, with more words queued
        push(32'h1200_4433, a0);
        push($urandom, a);
        push($urandom, a);
        wait_cyc(a0 + 95);
        chk("pre_rst_out", {31'b0, dout}, 32'd0);
        rst = 1'b1;
        exp_q.delete();
        #1;
        chk("rst_async_out", {31'b0, dout}, 32'd1);
        chk("rst_async_ready", {31'b0, dready}, 32'd1);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (2) @(negedge clk);
        push(32'h0000_00A5, a);
        drain();

        repeat (50) @(negedge clk);
        chk("leftover_bytes", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
